// File: rtl/sampler_mem_arbiter.sv
// Two-master round-robin arbiter sharing the single-port sample memory between
// the CPU data master (m0) and the capture engine (m1), with a bounded hold window.
module sampler_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int BE_W     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    function automatic logic [3:0] hold_inc(input logic [3:0] h);
        return (h >= HOLD_MAX) ? h : h + 4'd1;
    endfunction

    logic              ready;
    logic              owner;
    logic              last_win;
    logic [3:0]        hold;
    logic [3:0]        hold_nxt;
    logic              rd_pending_p1;
    logic              rd_owner_p1;
    logic              req0;
    logic              req1;
    logic              issue;
    logic              win;
    logic              win_write;
    logic [ADDR_W-1:0] win_address;
    logic [BE_W-1:0]   win_byteenable;
    logic [DATA_W-1:0] win_writedata;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wd_q;

    // Grant decision: win = 1 selects m1. Nothing issues until the first edge after reset.
    always_comb begin
        req0     = m0_read | m0_write;
        req1     = m1_read | m1_write;
        issue    = 1'b0;
        win      = owner;
        hold_nxt = '0;
        if (ready) begin
            if (req0 && req1) begin
                issue = 1'b1;
                win   = (hold < HOLD_MAX) ? owner : ~last_win;
            end else if (req0) begin
                issue = 1'b1;
                win   = 1'b0;
            end else if (req1) begin
                issue = 1'b1;
                win   = 1'b1;
            end
        end
        if (issue) begin
            hold_nxt = (win == owner) ? hold_inc(hold) : 4'd1;
        end
    end

    always_comb begin
        win_address    = win ? m1_address    : m0_address;
        win_byteenable = win ? m1_byteenable : m0_byteenable;
        win_writedata  = win ? m1_writedata  : m0_writedata;
        win_write      = win ? m1_write      : m0_write;
    end

    assign mem_address    = issue ? win_address    : addr_q;
    assign mem_byteenable = issue ? win_byteenable : be_q;
    assign mem_writedata  = issue ? win_writedata  : wd_q;
    assign mem_chipselect = issue;
    assign mem_write      = issue & win_write;
    assign mem_clken      = reset_n;

    assign m0_waitrequest = ~(issue & ~win);
    assign m1_waitrequest = ~(issue & win);

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pending_p1 & ~rd_owner_p1;
    assign m1_readdatavalid = rd_pending_p1 & rd_owner_p1;

    // Arbitration state and read-return tag (p1: one cycle after issue).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready         <= 1'b0;
            owner         <= 1'b0;
            last_win      <= 1'b1;
            hold          <= '0;
            rd_pending_p1 <= 1'b0;
            rd_owner_p1   <= 1'b0;
        end else begin
            ready         <= 1'b1;
            hold          <= hold_nxt;
            rd_pending_p1 <= issue & ~win_write;
            if (issue) begin
                owner       <= win;
                last_win    <= win;
                rd_owner_p1 <= win;
            end
        end
    end

    // Last driven memory bus values, held while idle so the bus does not toggle.
    always_ff @(posedge clk) begin
        if (issue) begin
            addr_q <= win_address;
            be_q   <= win_byteenable;
            wd_q   <= win_writedata;
        end
    end

endmodule
